sweep_game_engine: RTL and testbench

//  Parametrised "stop-the-light" game core for an N-LED WS2812 strip. A red cursor

---
 rtl/sweep_game_engine.sv | 204 ++++++++++++++++++++
 tb/tb_sweep_game_engine.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_game_engine.sv
// Stop-the-light game core: a red cursor bounces along an N-LED strip and the
// player stops it on the target LED; the packed GRB frame feeds the strip serialiser.
module sweep_game_engine #(
  parameter int NUM_LEDS   = 8,
  parameter int TARGET     = 4,
  parameter int BASE_TICK  = 2**24,
  parameter int NUM_LEVELS = 5,
  parameter int LIVES      = 3,
  parameter int HOLD_TICKS = 4,
  localparam int LW        = $clog2(LIVES + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  input  logic                     go,
  output logic [24*NUM_LEDS-1:0]   grb_out,
  output logic [2:0]               level,
  output logic [LW-1:0]            lives,
  output logic                     step,
  output logic                     hit,
  output logic                     miss,
  output logic                     game_over
);

  localparam int PW = $clog2(NUM_LEDS);
  localparam int CW = $clog2(BASE_TICK + 1);
  localparam int HW = $clog2(HOLD_TICKS + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SWEEP = 3'd1;
  localparam logic [2:0] S_HIT   = 3'd2;
  localparam logic [2:0] S_MISS  = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  localparam logic [23:0] RED    = 24'h00FF00;
  localparam logic [23:0] WHITE  = 24'hFFFFFF;
  localparam logic [23:0] OFF    = 24'h000000;
  localparam logic [23:0] ORANGE = 24'h66FF00;
  localparam logic [23:0] GREEN  = 24'hFF0000;
  localparam logic [23:0] CYAN   = 24'hFF00FF;
  localparam logic [23:0] BLUE   = 24'h0000FF;
  localparam logic [23:0] VIOLET = 24'h0066FF;

  localparam logic [PW-1:0] TGT_POS   = PW'(TARGET);
  localparam logic [PW-1:0] LAST_POS  = PW'(NUM_LEDS - 1);
  localparam logic [2:0]    LVL_MAX   = 3'(NUM_LEVELS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [LW-1:0] LIVES_INI = LW'(LIVES);
  localparam logic [CW-1:0] BASE_CNT  = CW'(BASE_TICK);

  logic [2:0]    state_reg;
  logic [PW-1:0] pos_reg;
  logic          dir_up_reg;
  logic [2:0]    level_reg;
  logic [LW-1:0] lives_reg;
  logic [CW-1:0] cnt_reg;
  logic [HW-1:0] hold_reg;
  logic          go_d_reg;
  logic          hit_reg;
  logic          miss_reg;

  logic          go_edge;
  logic          active;
  logic [CW-1:0] period;
  logic          step_w;
  logic [23:0]   lvl_colour;

  assign go_edge = go & ~go_d_reg;
  assign active  = (state_reg == S_SWEEP) || (state_reg == S_HIT) || (state_reg == S_MISS);
  // Each level halves the step period.
  assign period  = BASE_CNT >> level_reg;
  assign step_w  = run && active && (cnt_reg == period - 1'b1);

  always_comb begin
    lvl_colour = VIOLET;
    case (level_reg)
      3'd0:    lvl_colour = ORANGE;
      3'd1:    lvl_colour = GREEN;
      3'd2:    lvl_colour = CYAN;
      3'd3:    lvl_colour = BLUE;
      default: lvl_colour = VIOLET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      pos_reg    <= '0;
      dir_up_reg <= 1'b1;
      level_reg  <= '0;
      lives_reg  <= LIVES_INI;
      cnt_reg    <= '0;
      hold_reg   <= '0;
      go_d_reg   <= 1'b0;
      hit_reg    <= 1'b0;
      miss_reg   <= 1'b0;
    end else begin
      go_d_reg <= go;
      hit_reg  <= 1'b0;
      miss_reg <= 1'b0;
      if (run && active)
        cnt_reg <= step_w ? '0 : cnt_reg + 1'b1;

      // Every state change below also clears the tick counter.
      case (state_reg)
        S_IDLE: begin
          if (go_edge) begin
            state_reg  <= S_SWEEP;
            pos_reg    <= '0;
            dir_up_reg <= 1'b1;
            cnt_reg    <= '0;
          end
        end
        S_SWEEP: begin
          if (go_edge && run) begin
            cnt_reg  <= '0;
            hold_reg <= '0;
            if (pos_reg == TGT_POS) begin
              state_reg <= S_HIT;
              hit_reg   <= 1'b1;
              if (level_reg != LVL_MAX)
                level_reg <= level_reg + 1'b1;
            end else begin
              state_reg <= S_MISS;
              miss_reg  <= 1'b1;
              lives_reg <= lives_reg - 1'b1;
            end
          end else if (step_w) begin
            if (dir_up_reg) begin
              pos_reg <= pos_reg + 1'b1;
              if (pos_reg == LAST_POS - 1'b1)
                dir_up_reg <= 1'b0;
            end else begin
              pos_reg <= pos_reg - 1'b1;
              if (pos_reg == PW'(1))
                dir_up_reg <= 1'b1;
            end
          end
        end
        S_HIT, S_MISS: begin
          if (step_w) begin
            if (hold_reg == HOLD_LAST) begin
              hold_reg <= '0;
              cnt_reg  <= '0;
              if (state_reg == S_MISS && lives_reg == '0) begin
                state_reg <= S_OVER;
              end else begin
                state_reg  <= S_SWEEP;
                pos_reg    <= '0;
                dir_up_reg <= 1'b1;
              end
            end else begin
              hold_reg <= hold_reg + 1'b1;
            end
          end
        end
        S_OVER: begin
          if (go_edge) begin
            state_reg <= S_IDLE;
            level_reg <= '0;
            lives_reg <= LIVES_INI;
            cnt_reg   <= '0;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // One colour mux per LED; LED0 occupies the most significant 24 bits.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LEDS; gi++) begin : g_led
      logic [23:0] led;
      always_comb begin
        led = OFF;
        case (state_reg)
          S_IDLE:  led = (gi == TARGET) ? lvl_colour : OFF;
          S_SWEEP: begin
            if (pos_reg == PW'(gi))
              led = RED;
            else if (gi == TARGET)
              led = OFF;
            else
              led = lvl_colour;
          end
          S_HIT:   led = WHITE;
          S_MISS:  led = (pos_reg == PW'(gi)) ? RED : OFF;
          S_OVER:  led = RED;
          default: led = OFF;
        endcase
      end
      assign grb_out[24*(NUM_LEDS-gi)-1 -: 24] = led;
    end
  endgenerate

  assign level     = level_reg;
  assign lives     = lives_reg;
  assign step      = step_w;
  assign hit       = hit_reg;
  assign miss      = miss_reg;
  assign game_over = (state_reg == S_OVER);

endmodule

// File: tb/tb_sweep_game_engine.sv
// Bench for sweep_game_engine: directed game scenarios plus random play, checked every
// cycle against a step-count based model of the game rules.
module tb_sweep_game_engine;

  localparam int NL  = 5;
  localparam int TGT = 2;
  localparam int BT  = 16;
  localparam int NLV = 5;
  localparam int LV  = 2;
  localparam int HT  = 2;

  localparam int S_IDLE  = 0;
  localparam int S_SWEEP = 1;
  localparam int S_HIT   = 2;
  localparam int S_MISS  = 3;
  localparam int S_OVER  = 4;

  localparam logic [23:0] RED   = 24'h00FF00;
  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] OFF   = 24'h000000;

  logic          clk;
  logic          reset;
  logic          run;
  logic          go;
  logic [119:0]  grb_out;
  logic [2:0]    level;
  logic [1:0]    lives;
  logic          step;
  logic          hit;
  logic          miss;
  logic          game_over;

  sweep_game_engine #(
    .NUM_LEDS(NL), .TARGET(TGT), .BASE_TICK(BT),
    .NUM_LEVELS(NLV), .LIVES(LV), .HOLD_TICKS(HT)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .go(go),
    .grb_out(grb_out), .level(level), .lives(lives),
    .step(step), .hit(hit), .miss(miss), .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: game phase, steps taken in the phase, clocks into the current tick period.
  int m_state   = S_IDLE;
  int m_nsteps  = 0;
  int m_elapsed = 0;
  int m_level   = 0;
  int m_lives   = LV;
  int m_cursor  = 0;
  bit m_go_prev = 1'b0;
  bit m_hit     = 1'b0;
  bit m_miss    = 1'b0;

  function automatic int bounce(input int k);
    int span;
    int m;
    span = 2 * (NL - 1);
    m = k % span;
    return (m < NL) ? m : span - m;
  endfunction

  function automatic logic [23:0] col(input int l);
    case (l)
      0:       return 24'h66FF00;
      1:       return 24'hFF0000;
      2:       return 24'hFF00FF;
      3:       return 24'h0000FF;
      default: return 24'h0066FF;
    endcase
  endfunction

  function automatic int period_now();
    return BT >> m_level;
  endfunction

  function automatic bit model_active();
    return (m_state == S_SWEEP) || (m_state == S_HIT) || (m_state == S_MISS);
  endfunction

  function automatic logic [119:0] exp_frame();
    logic [119:0] f;
    logic [23:0]  c;
    int p;
    f = '0;
    p = bounce(m_nsteps);
    for (int i = 0; i < NL; i++) begin
      case (m_state)
        S_IDLE:  c = (i == TGT) ? col(m_level) : OFF;
        S_SWEEP: c = (i == p) ? RED : ((i == TGT) ? OFF : col(m_level));
        S_HIT:   c = WHITE;
        S_MISS:  c = (i == m_cursor) ? RED : OFF;
        default: c = RED;
      endcase
      f[24*(NL-i)-1 -: 24] = c;
    end
    return f;
  endfunction

  task automatic model_clock(input logic r, input logic g, input logic rst);
    bit edge_g;
    bit st;
    int p;
    if (rst) begin
      m_state = S_IDLE; m_nsteps = 0; m_elapsed = 0; m_level = 0;
      m_lives = LV; m_go_prev = 1'b0; m_hit = 1'b0; m_miss = 1'b0;
    end else begin
      edge_g = g && !m_go_prev;
      m_go_prev = g;
      st = r && model_active() && (m_elapsed == period_now() - 1);
      m_hit = 1'b0;
      m_miss = 1'b0;
      if (r && model_active())
        m_elapsed = st ? 0 : m_elapsed + 1;
      case (m_state)
        S_IDLE: if (edge_g) begin
          m_state = S_SWEEP; m_nsteps = 0; m_elapsed = 0;
        end
        S_SWEEP: begin
          if (edge_g && r) begin
            p = bounce(m_nsteps);
            m_nsteps = 0; m_elapsed = 0;
            if (p == TGT) begin
              m_hit = 1'b1; m_state = S_HIT;
              if (m_level < NLV - 1) m_level++;
            end else begin
              m_miss = 1'b1; m_state = S_MISS; m_lives--; m_cursor = p;
            end
            $display("t=%0t go at pos %0d -> %s, level=%0d lives=%0d",
                     $time, p, m_hit ? "hit" : "miss", m_level, m_lives);
          end else if (st) begin
            m_nsteps++;
          end
        end
        S_HIT, S_MISS: if (st) begin
          m_nsteps++;
          if (m_nsteps == HT) begin
            m_nsteps = 0; m_elapsed = 0;
            m_state = (m_state == S_MISS && m_lives == 0) ? S_OVER : S_SWEEP;
          end
        end
        default: if (edge_g) begin
          m_state = S_IDLE; m_level = 0; m_lives = LV;
        end
      endcase
    end
  endtask

  task automatic check(input string name, input logic [119:0] act, input logic [119:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    bit exp_step;
    exp_step = run && model_active() && (m_elapsed == period_now() - 1);
    check("grb_out",   grb_out,          exp_frame());
    check("level",     120'(level),      120'(m_level));
    check("lives",     120'(lives),      120'(m_lives));
    check("step",      120'(step),       120'(exp_step));
    check("hit",       120'(hit),        120'(m_hit));
    check("miss",      120'(miss),       120'(m_miss));
    check("game_over", 120'(game_over),  120'(m_state == S_OVER));
  endtask

  task automatic cycle(input logic r, input logic g, input logic rst);
    run = r; go = g; reset = rst;
    @(posedge clk);
    model_clock(r, g, rst);
    #2;
    compare_all();
  endtask

  task automatic wait_sweep_pos(input int p, input bit at_step);
    int n;
    n = 0;
    cycle(1'b1, 1'b0, 1'b0);
    while (!(m_state == S_SWEEP && bounce(m_nsteps) == p &&
             (!at_step || m_elapsed == period_now() - 1)) && n < 3000) begin
      cycle(1'b1, 1'b0, 1'b0);
      n++;
    end
    n_vec++;
    if (n >= 3000) begin
      n_err++;
      $display("FAIL wait_pos: no sweep at pos %0d within 3000 cycles", p);
    end
  endtask

  task automatic wait_state(input int s);
    int n;
    n = 0;
    while (m_state != s && n < 3000) begin
      cycle(1'b1, 1'b0, 1'b0);
      n++;
    end
    n_vec++;
    if (n >= 3000) begin
      n_err++;
      $display("FAIL wait_state: state %0d not reached within 3000 cycles", s);
    end
  endtask

  task automatic measure_step_gap(input int expv);
    int n;
    n = 0;
    while (step !== 1'b1 && n < 100) begin cycle(1'b1, 1'b0, 1'b0); n++; end
    n = 0;
    cycle(1'b1, 1'b0, 1'b0);
    n = 1;
    while (step !== 1'b1 && n < 100) begin cycle(1'b1, 1'b0, 1'b0); n++; end
    check("step_gap", 120'(n), 120'(expv));
  endtask

  initial begin
    int pulses;
    int steps_seen;
    reset = 1'b1; run = 1'b0; go = 1'b0;
    repeat (3) cycle(1'b0, 1'b0, 1'b1);
    check("reset_frame", grb_out, 120'h000000_000000_66FF00_000000_000000);
    check("reset_level", 120'(level), 120'd0);
    check("reset_lives", 120'(lives), 120'd2);
    check("reset_over",  120'(game_over), 120'd0);

    // Start and sweep at level 0
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    measure_step_gap(16);

    // Hit on the target
    wait_sweep_pos(2, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    check("hit_pulse", 120'(hit), 120'd1);
    check("hit_level", 120'(level), 120'd1);
    check("hit_frame", grb_out, {5{WHITE}});
    measure_step_gap(8);

    // Two misses to game over, then back to idle
    wait_sweep_pos(3, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    check("miss_pulse", 120'(miss), 120'd1);
    check("miss_lives", 120'(lives), 120'd1);
    check("miss_frame", grb_out, 120'h000000_000000_000000_00FF00_000000);
    wait_sweep_pos(3, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    check("miss2_lives", 120'(lives), 120'd0);
    wait_state(S_OVER);
    check("over_frame", grb_out, {5{RED}});
    check("over_flag", 120'(game_over), 120'd1);
    cycle(1'b0, 1'b1, 1'b0);
    check("restart_lives", 120'(lives), 120'd2);
    check("restart_level", 120'(level), 120'd0);
    check("restart_frame", grb_out, 120'h000000_000000_66FF00_000000_000000);

    // go rising on the step cycle at the target, then held high
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    wait_sweep_pos(2, 1'b1);
    cycle(1'b1, 1'b1, 1'b0);
    check("edge_step_hit", 120'(hit), 120'd1);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      pulses += int'(hit) + int'(miss);
    end
    check("held_go_pulses", 120'(pulses), 120'd0);
    check("held_go_level", 120'(level), 120'd1);
    cycle(1'b1, 1'b0, 1'b0);

    // Pause mid-sweep
    wait_state(S_SWEEP);
    repeat (5) cycle(1'b1, 1'b0, 1'b0);
    pulses = 0;
    steps_seen = 0;
    for (int i = 0; i < 100; i++) begin
      cycle(1'b0, ((i >> 2) & 1) == 1, 1'b0);
      pulses += int'(hit) + int'(miss);
      steps_seen += int'(step);
    end
    check("pause_steps", 120'(steps_seen), 120'd0);
    check("pause_pulses", 120'(pulses), 120'd0);
    repeat (20) cycle(1'b1, 1'b0, 1'b0);

    // Climb to the top level, then saturate; reset mid-hit
    repeat (3) begin
      wait_sweep_pos(2, 1'b0);
      cycle(1'b1, 1'b1, 1'b0);
    end
    check("top_level", 120'(level), 120'd4);
    measure_step_gap(1);
    wait_sweep_pos(2, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    check("sat_hit", 120'(hit), 120'd1);
    check("sat_level", 120'(level), 120'd4);
    cycle(1'b1, 1'b0, 1'b1);
    check("midhit_reset_level", 120'(level), 120'd0);
    check("midhit_reset_lives", 120'(lives), 120'd2);
    check("midhit_reset_frame", grb_out, 120'h000000_000000_66FF00_000000_000000);

    // Random play
    for (int i = 0; i < 4000; i++)
      cycle($urandom_range(0, 15) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 999) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
